// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues word requests to instruction memory and
// writes returned words, tagged with their address, into the realign buffer.
module instr_fetch_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        buf_clear_o,
    output logic        buf_offset_o,
    output logic        buf_write_en_o,
    output logic [31:0] buf_instr_o,
    output logic [31:0] buf_addr_o,
    input  logic        buf_full_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_resp_addr;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_skid_cnt;
    logic [31:0]   r_skid_data [DEPTH];
    logic [31:0]   r_skid_addr [DEPTH];

    logic          w_boot;
    logic          w_run;
    logic          w_jump;
    logic [CW:0]   w_inflight;
    logic          w_room;
    logic          w_grant;
    logic          w_accept;
    logic          w_has_head;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_push_idx;
    logic          w_unused;

    assign w_boot     = (r_state == ST_BOOT);
    assign w_run      = (r_state == ST_RUN);
    assign w_jump     = w_run & jump_i;
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_skid_cnt};
    assign w_room     = (w_inflight < (CW + 1)'(DEPTH));
    assign w_unused   = ^{boot_addr_i[0], jump_target_i[0]};

    assign instr_req_o  = w_run & fetch_en_i & ~jump_i & w_room;
    assign instr_addr_o = r_fetch_addr;
    assign w_grant      = instr_req_o & instr_gnt_i;

    // A response is kept only when no stale responses remain to be discarded.
    assign w_accept   = w_run & instr_rvalid_i & ~jump_i & (r_drop_cnt == '0);
    assign w_has_head = (r_skid_cnt != '0);

    assign buf_clear_o    = w_boot | w_jump;
    assign buf_offset_o   = w_boot ? boot_addr_i[1] : (w_jump & jump_target_i[1]);
    assign buf_write_en_o = w_run & ~jump_i & ~buf_full_i & (w_has_head | w_accept);

    assign w_pop      = buf_write_en_o & w_has_head;
    assign w_push     = w_accept & ~(buf_write_en_o & ~w_has_head);
    assign w_push_idx = r_skid_cnt - CW'(w_pop);

    always_comb begin
        buf_instr_o = '0;
        buf_addr_o  = '0;
        if (w_has_head) begin
            buf_instr_o = r_skid_data[0];
            buf_addr_o  = r_skid_addr[0];
        end else if (w_accept) begin
            buf_instr_o = instr_rdata_i;
            buf_addr_o  = r_resp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_fetch_addr  <= '0;
            r_resp_addr   <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_skid_cnt    <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_fetch_addr <= {boot_addr_i[31:2], 2'b00};
                    r_resp_addr  <= {boot_addr_i[31:2], 2'b00};
                    r_state      <= ST_RUN;
                end
                default: begin
                    if (jump_i) begin
                        r_fetch_addr  <= {jump_target_i[31:2], 2'b00};
                        r_resp_addr   <= {jump_target_i[31:2], 2'b00};
                        r_outstanding <= r_outstanding - CW'(instr_rvalid_i);
                        r_drop_cnt    <= r_outstanding - CW'(instr_rvalid_i);
                        r_skid_cnt    <= '0;
                    end else begin
                        if (w_grant) begin
                            r_fetch_addr <= r_fetch_addr + 32'd4;
                        end
                        r_outstanding <= r_outstanding + CW'(w_grant) - CW'(instr_rvalid_i);
                        if (instr_rvalid_i && (r_drop_cnt != '0)) begin
                            r_drop_cnt <= r_drop_cnt - 1'b1;
                        end
                        if (w_accept) begin
                            r_resp_addr <= r_resp_addr + 32'd4;
                        end
                        r_skid_cnt <= r_skid_cnt + CW'(w_push) - CW'(w_pop);
                    end
                end
            endcase
        end
    end

    // Head-at-zero shift FIFO: a same-cycle pop and push lands the new word
    // one slot lower, so the later push assignment overrides the shift.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                r_skid_data[i] <= r_skid_data[i + 1];
                r_skid_addr[i] <= r_skid_addr[i + 1];
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_push && (w_push_idx == CW'(i))) begin
                r_skid_data[i] <= instr_rdata_i;
                r_skid_addr[i] <= r_resp_addr;
            end
        end
    end

    a_budget: assert property (@(posedge clk) disable iff (!rst_n)
        w_inflight <= (CW + 1)'(DEPTH));
    a_skid_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_skid_cnt == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed scoreboard bench for instr_fetch_ctrl with a one-cycle-latency
// instruction memory whose responses can be held back per cycle.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] boot_addr_i;
    logic        fetch_en_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        buf_clear_o;
    logic        buf_offset_o;
    logic        buf_write_en_o;
    logic [31:0] buf_instr_o;
    logic [31:0] buf_addr_o;
    logic        buf_full_i;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_wr_q  [$];
    logic        exp_clr_q [$];
    logic [31:0] mem_q     [$];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_addr_i    (boot_addr_i),
        .fetch_en_i     (fetch_en_i),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .buf_clear_o    (buf_clear_o),
        .buf_offset_o   (buf_offset_o),
        .buf_write_en_o (buf_write_en_o),
        .buf_instr_o    (buf_instr_o),
        .buf_addr_o     (buf_addr_o),
        .buf_full_i     (buf_full_i)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; memory answers in order, one cycle after grant.
    task automatic cyc(input bit fe, input bit g, input bit rv, input bit full,
                       input bit jmp, input logic [31:0] tgt);
        logic [31:0] a;
        @(negedge clk);
        fetch_en_i    = fe;
        instr_gnt_i   = g;
        buf_full_i    = full;
        jump_i        = jmp;
        jump_target_i = tgt;
        if (rv && mem_q.size() > 0) begin
            a = mem_q.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = memf(a);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = '0;
        end
        #1;
        if (instr_req_o && instr_gnt_i) mem_q.push_back(instr_addr_o);
    endtask

    task automatic step();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic chk_reset_outputs(input logic exp_off);
        chk("rst_req",   32'(instr_req_o),    32'h0);
        chk("rst_addr",  instr_addr_o,        32'h0);
        chk("rst_wen",   32'(buf_write_en_o), 32'h0);
        chk("rst_instr", buf_instr_o,         32'h0);
        chk("rst_baddr", buf_addr_o,          32'h0);
        chk("rst_clear", 32'(buf_clear_o),    32'h1);
        chk("rst_off",   32'(buf_offset_o),   32'(exp_off));
    endtask

    // Monitor: every buffer write and clear is checked against the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        logic        eo;
        #2;
        if (rst_n === 1'b1) begin
            if (buf_write_en_o) begin
                if (exp_wr_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_write: got addr 0x%08h, expected no write", buf_addr_o);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", buf_addr_o, e);
                    chk("wr_data", buf_instr_o, memf(e));
                end
            end
            if (buf_clear_o) begin
                if (exp_clr_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_clear: got clear, expected none");
                end else begin
                    eo = exp_clr_q.pop_front();
                    chk("clr_offset", 32'(buf_offset_o), 32'(eo));
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        boot_addr_i    = 32'h0000_0102;
        fetch_en_i     = 1'b1;
        jump_i         = 1'b0;
        jump_target_i  = '0;
        instr_gnt_i    = 1'b1;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        buf_full_i     = 1'b0;

        #2;
        chk_reset_outputs(1'b1);
        boot_addr_i = 32'h0000_0100;
        #1;
        chk("rst_off_boot100", 32'(buf_offset_o), 32'h0);

        // Boot and streaming
        exp_clr_q.push_back(1'b0);
        exp_wr_q.push_back(32'h100);
        exp_wr_q.push_back(32'h104);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", 32'(instr_req_o), 32'h0);
        step();
        chk("req_first", 32'(instr_req_o), 32'h1);
        chk("addr_first", instr_addr_o, 32'h100);
        step();
        chk("bypass_wen", 32'(buf_write_en_o), 32'h1);
        chk("addr_second", instr_addr_o, 32'h104);
        step();

        // Backpressure for 5 cycles
        exp_wr_q.push_back(32'h108);
        exp_wr_q.push_back(32'h10C);
        exp_wr_q.push_back(32'h110);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("full_wen", 32'(buf_write_en_o), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("full_req_drop", 32'(instr_req_o), 32'h0);
        end
        chk("skid_count", 32'(dut.r_skid_cnt), 32'h2);
        step();
        chk("drain1_wen", 32'(buf_write_en_o), 32'h1);
        chk("drain1_req", 32'(instr_req_o), 32'h0);
        step();
        chk("drain2_wen", 32'(buf_write_en_o), 32'h1);
        chk("drain2_addr", instr_addr_o, 32'h110);
        step();

        // Jump with two requests in flight
        exp_clr_q.push_back(1'b1);
        exp_wr_q.push_back(32'h208);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20A);
        chk("jump_req", 32'(instr_req_o), 32'h0);
        chk("jump_wen", 32'(buf_write_en_o), 32'h0);
        step();
        chk("drop1_wen", 32'(buf_write_en_o), 32'h0);
        chk("drop1_req", 32'(instr_req_o), 32'h0);
        step();
        chk("drop2_wen", 32'(buf_write_en_o), 32'h0);
        chk("target_addr", instr_addr_o, 32'h208);
        step();
        chk("target_wen", 32'(buf_write_en_o), 32'h1);

        // Jump coincident with rvalid and buffer full
        exp_clr_q.push_back(1'b0);
        exp_wr_q.push_back(32'h300);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
        chk("jfull_wen", 32'(buf_write_en_o), 32'h0);
        step();
        chk("jfull_drop_cnt", 32'(dut.r_drop_cnt), 32'h1);
        chk("jfull_drop_wen", 32'(buf_write_en_o), 32'h0);
        chk("jfull_addr", instr_addr_o, 32'h300);
        step();

        // Grant stall then jump
        exp_wr_q.push_back(32'h304);
        exp_clr_q.push_back(1'b0);
        exp_wr_q.push_back(32'h40);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_addr", instr_addr_o, 32'h308);
            chk("stall_wen", 32'(buf_write_en_o), 32'h0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
        chk("stall_jump_req", 32'(instr_req_o), 32'h0);
        step();
        chk("stall_new_addr", instr_addr_o, 32'h40);
        chk("stall_new_wen", 32'(buf_write_en_o), 32'h0);
        step();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset mid-fetch with two responses pending
        @(negedge clk);
        rst_n          = 1'b0;
        boot_addr_i    = 32'h0000_0500;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = '0;
        mem_q.delete();
        #1;
        chk_reset_outputs(1'b0);
        @(negedge clk);
        exp_clr_q.push_back(1'b0);
        exp_wr_q.push_back(32'h500);
        exp_wr_q.push_back(32'h504);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reboot_req", 32'(instr_req_o), 32'h0);
        step();
        chk("reboot_addr", instr_addr_o, 32'h500);
        step();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("fetch_dis_req", 32'(instr_req_o), 32'h0);
        chk("fetch_dis_wen", 32'(buf_write_en_o), 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("idle_wen", 32'(buf_write_en_o), 32'h0);

        #3;
        chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'h0);
        chk("clr_queue_empty", 32'(exp_clr_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller: the producer side of the realign buffer. It issues word-aligned requests on the instruction memory req/gnt/rvalid interface and pushes returned words into the realign buffer in order, each tagged with its address. It never overflows the buffer, and on jumps it clears the buffer and discards stale in-flight responses. It sits between instruction memory and the realign buffer, under control of the core's jump logic.

## Interface
Parameters:
- DEPTH, default 2: maximum granted-but-unreturned requests plus skid FIFO entries; also the skid FIFO depth.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- boot_addr_i  in  32  first fetch address; sampled in the BOOT cycle.
- fetch_en_i  in  1  permits issuing new requests.
- jump_i  in  1  single-cycle redirect request.
- jump_target_i  in  32  redirect target, halfword aligned; bit 0 ignored.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  request address, bits [1:0] = 0.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  response data valid.
- instr_rdata_i  in  32  response word.
- buf_clear_o  out  1  clear pulse to the buffer.
- buf_offset_o  out  1  halfword offset loaded into the buffer with the clear.
- buf_write_en_o  out  1  write a word into the buffer.
- buf_instr_o  out  32  word written.
- buf_addr_o  out  32  word address of that word, bits [1:0] = 0.
- buf_full_i  in  1  buffer full; no write this cycle.

## Operation
- State machine: BOOT and RUN. Reset enters BOOT.
- BOOT (exactly 1 cycle):
  - buf_clear_o=1, buf_offset_o=boot_addr_i[1].
  - fetch_addr and resp_addr load {boot_addr_i[31:2],2'b00}.
  - instr_req_o=0; jump_i is ignored.
  - Next state is RUN.
- RUN, issue:
  - instr_req_o = fetch_en_i & ~jump_i & (outstanding + skid_count < DEPTH).
  - instr_addr_o = fetch_addr.
  - On req & gnt: fetch_addr += 4 and outstanding increments.
  - instr_req_o may drop before gnt, because the memory side tolerates withdrawal.
- RUN, response:
  - On rvalid, outstanding decrements.
  - If drop_cnt > 0: the word is discarded and drop_cnt decrements.
  - Otherwise the word is accepted, tagged with resp_addr, and resp_addr += 4.
- RUN, buffer write:
  - If the skid FIFO is non-empty, its head is the write candidate.
  - Otherwise an accepted rvalid word is the candidate (bypass).
  - buf_write_en_o = candidate exists & ~buf_full_i & ~jump_i. A write pops the head, or consumes the bypass word.
  - An accepted word that is not written the same cycle is pushed to the skid FIFO tail. If the head is popped and a new word arrives in the same cycle, the new word goes to the tail, preserving order.
- RUN, jump (jump_i=1):
  - buf_clear_o=1, buf_offset_o=jump_target_i[1].
  - The skid FIFO is flushed and no buffer write occurs.
  - fetch_addr and resp_addr load {jump_target_i[31:2],2'b00}.
  - drop_cnt loads outstanding - instr_rvalid_i, so every response still in flight is discarded. The rvalid word of the jump cycle is discarded too.
  - instr_req_o=0 for the jump cycle.
- Arithmetic:
  - Addresses wrap modulo 2^32.
  - outstanding, drop_cnt and skid_count are clog2(DEPTH+1) bits wide.
  - outstanding + skid_count ≤ DEPTH at all times. Skid FIFO overflow is a bug and is checked by assertion.
- fetch_en_i=0 stops new requests only. Outstanding responses still complete and are written.

## Timing
- Reset values:
  - instr_req_o=0, instr_addr_o=0.
  - buf_write_en_o=0, buf_instr_o=0, buf_addr_o=0.
  - buf_clear_o=1, with buf_offset_o=boot_addr_i[1], because BOOT is combinationally active during reset.
  - All counters are 0.
- The first request can issue in the cycle after BOOT.
- Bypass latency: rvalid in cycle t produces buf_write_en_o in cycle t, zero cycles.
- The first new-target request issues in the cycle after the jump.
- jump_i and buf_full_i together: the jump wins; the clear empties the buffer.
- rst_n asserted mid-operation: all in-flight tracking is lost and the block returns to BOOT. Memory is reset alongside.

## Test plan
- Boot: boot_addr_i=0x100, fetch_en_i=1, gnt always, rvalid one cycle after grant.
  - Required: BOOT clear with offset 0.
  - Requests issue to 0x100, 0x104, …
  - Buffer writes carry buf_addr_o 0x100, 0x104 in order, each in its rvalid cycle.
- Backpressure: hold buf_full_i=1 for 5 cycles.
  - Required: at most DEPTH=2 words are skidded and instr_req_o drops.
  - After release, words drain in order 0x108 then 0x10C, one per cycle, with no loss or duplication.
- Jump with 2 outstanding: jump_target_i=0x20A while 2 requests are in flight.
  - Required: buf_clear_o=1, buf_offset_o=1.
  - Both stale responses are dropped, with no write.
  - The next request is to 0x208, and its word is written with buf_addr_o=0x208.
- Jump coincident with rvalid and buf_full_i=1.
  - Required: that rvalid word is dropped and drop_cnt = outstanding-1.
- Grant stall: gnt=0 for 4 cycles, then jump to 0x40.
  - Required: instr_addr_o holds the old address until the jump cycle, then shows 0x40; no spurious write.
- Reset asserted mid-fetch with responses pending.
  - Required: all outputs at their reset values; after release, fetch restarts from boot_addr_i.
